// File: rtl/sa_cache_pkg.sv
// Shared widths, controller state encoding and line-address helper for the sa_cache memory side.
package sa_cache_pkg;

    localparam int TAG_W    = 18;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 6;
    localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;
    localparam int DATA_W   = 32;
    localparam int WB_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RD_REQ,
        RD_WAIT,
        RESP,
        HOLD,
        DRAIN
    } ctrl_state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/sa_cache_wb_buf.sv
// Write-back FIFO with per-entry valid and an associative line match returning the youngest hit.
// Zero-latency match and head view; push is refused while full, pop is ignored while empty.
module sa_cache_wb_buf #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OFFSET_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_addr,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W-1:0]      head_addr,
    output logic [DATA_W-1:0]      head_data,
    input  logic [ADDR_W-OFFSET_W-1:0] match_line,
    output logic                   match_hit,
    output logic [DATA_W-1:0]      match_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic              do_push;
    logic              do_pop;
    logic [PW-1:0]     idx;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                addr_q[wr_ptr_q] <= push_addr;
                data_q[wr_ptr_q] <= push_data;
                vld_q[wr_ptr_q]  <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            // Push and pop never target the same slot: push needs !full, pop needs !empty.
            if (do_pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last hit wins; an entry arriving this cycle is youngest of all.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (vld_q[idx] && (addr_q[idx][ADDR_W-1:OFFSET_W] == match_line)) begin
                match_hit  = 1'b1;
                match_data = data_q[idx];
            end
        end
        if (do_push && (push_addr[ADDR_W-1:OFFSET_W] == match_line)) begin
            match_hit  = 1'b1;
            match_data = push_data;
        end
    end

endmodule

// File: rtl/sa_cache_mem_ctrl.sv
// Memory-side controller for sa_cache: refills misses (forwarding from buffered evictions) and drains write-backs.
// Refill 4+ cycles from memory, 2 when forwarded; evictions stall on !o_evict_ready, requests hold until i_mem_ready.
module sa_cache_mem_ctrl #(
    parameter int WB_DEPTH = sa_cache_pkg::WB_DEPTH,
    parameter int ADDR_W   = sa_cache_pkg::ADDR_W,
    parameter int DATA_W   = sa_cache_pkg::DATA_W,
    parameter int TAG_W    = sa_cache_pkg::TAG_W,
    parameter int INDEX_W  = sa_cache_pkg::INDEX_W,
    parameter int OFFSET_W = sa_cache_pkg::OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_miss,
    input  logic [TAG_W-1:0]   i_miss_tag,
    input  logic [INDEX_W-1:0] i_miss_index,
    input  logic               i_evict,
    input  logic [ADDR_W-1:0]  i_evict_addr,
    input  logic [DATA_W-1:0]  i_evict_data,
    output logic               o_evict_ready,
    output logic [DATA_W-1:0]  o_memory_line,
    output logic               o_memory_response,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0]  o_mem_wdata,
    input  logic               i_mem_ready,
    input  logic               i_mem_rvalid,
    input  logic [DATA_W-1:0]  i_mem_rdata,
    output logic               o_busy
);

    import sa_cache_pkg::*;

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    logic [ADDR_W-1:0] refill_addr_q;
    logic [DATA_W-1:0] line_q;
    logic              rdy_en_q;

    logic              buf_push;
    logic              buf_pop;
    logic              buf_full;
    logic              buf_empty;
    logic [ADDR_W-1:0] buf_head_addr;
    logic [DATA_W-1:0] buf_head_data;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_hit_data;

    // Ready is held low through reset and rises on the first clock after release.
    assign o_evict_ready = rdy_en_q && !buf_full;
    assign buf_push      = i_evict && o_evict_ready;
    assign buf_pop       = (state_q == DRAIN) && i_mem_ready;
    assign o_busy        = (state_q != IDLE) || !buf_empty;

    sa_cache_wb_buf #(
        .DEPTH    (WB_DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OFFSET_W (OFFSET_W)
    ) u_wb_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .push_addr  (i_evict_addr),
        .push_data  (i_evict_data),
        .pop        (buf_pop),
        .full       (buf_full),
        .empty      (buf_empty),
        .head_addr  (buf_head_addr),
        .head_data  (buf_head_data),
        .match_line (refill_addr_q[ADDR_W-1:OFFSET_W]),
        .match_hit  (buf_hit),
        .match_data (buf_hit_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            refill_addr_q <= '0;
            line_q        <= '0;
            rdy_en_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if ((state_q == IDLE) && i_miss) begin
                refill_addr_q <= line_addr(i_miss_tag, i_miss_index);
            end
            if ((state_q == LOOKUP) && buf_hit) begin
                line_q <= buf_hit_data;
            end else if ((state_q == RD_WAIT) && i_mem_rvalid) begin
                line_q <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        o_mem_req         = 1'b0;
        o_mem_we          = 1'b0;
        o_mem_addr        = '0;
        o_mem_wdata       = '0;
        o_memory_response = 1'b0;
        o_memory_line     = '0;
        case (state_q)
            IDLE: begin
                if (i_miss) begin
                    state_d = LOOKUP;
                end else if (!buf_empty) begin
                    state_d = DRAIN;
                end
            end
            // A buffered copy is newer than memory, so a hit must never fall through to a read.
            LOOKUP: begin
                state_d = buf_hit ? RESP : RD_REQ;
            end
            RD_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = refill_addr_q;
                if (i_mem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                o_memory_response = 1'b1;
                o_memory_line     = line_q;
                state_d           = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            DRAIN: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = buf_head_addr;
                o_mem_wdata = buf_head_data;
                if (i_mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
